// File: rtl/register_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : register_file_scoreboard
// Brief    : 2-write / 2-async-read register file with per-register pending
//            (scoreboard) bits and a registered busy count.
//            Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read
//            forwarding on data and pending outputs.
// Revision : 1.0
// ============================================================================
module register_file_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT),
    parameter int ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_selector_1,
    input  logic [ADDR_WIDTH-1:0] read_selector_2,
    output logic [DATA_WIDTH-1:0] read_value_1,
    output logic [DATA_WIDTH-1:0] read_value_2,
    output logic                  pending_1,
    output logic                  pending_2,
    input  logic                  write_enable_a,
    input  logic [ADDR_WIDTH-1:0] write_selector_a,
    input  logic [DATA_WIDTH-1:0] write_value_a,
    input  logic                  write_enable_b,
    input  logic [ADDR_WIDTH-1:0] write_selector_b,
    input  logic [DATA_WIDTH-1:0] write_value_b,
    input  logic                  reserve_enable,
    input  logic [ADDR_WIDTH-1:0] reserve_selector,
    output logic [ADDR_WIDTH:0]   busy_count
);

    localparam logic [REG_COUNT-1:0] c_ZERO_MASK =
        (ZERO_REG != 0) ? REG_COUNT'(1) : '0;

    logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
    logic [REG_COUNT-1:0]  r_pending;
    logic [ADDR_WIDTH:0]   r_busy_count;

    logic [REG_COUNT-1:0]  w_wr_a;
    logic [REG_COUNT-1:0]  w_wr_b;
    logic [REG_COUNT-1:0]  w_rsv;
    logic [REG_COUNT-1:0]  w_clr;
    logic [REG_COUNT-1:0]  w_pend_next;
    logic [ADDR_WIDTH:0]   w_next_count;

    // One-hot decodes with register 0 masked out when it is hardwired to zero.
    assign w_wr_a = write_enable_a ? ((REG_COUNT'(1) << write_selector_a) & ~c_ZERO_MASK) : '0;
    assign w_wr_b = write_enable_b ? ((REG_COUNT'(1) << write_selector_b) & ~c_ZERO_MASK) : '0;
    assign w_rsv  = reserve_enable ? ((REG_COUNT'(1) << reserve_selector) & ~c_ZERO_MASK) : '0;
    assign w_clr  = w_wr_a | w_wr_b;

    // A reservation always beats a same-cycle clear: it names a new producer.
    assign w_pend_next = (r_pending & ~w_clr) | w_rsv;

    always_comb begin
        w_next_count = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            w_next_count = w_next_count + (ADDR_WIDTH+1)'(w_pend_next[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending    <= '0;
            r_busy_count <= '0;
        end else begin
            r_pending    <= w_pend_next;
            r_busy_count <= w_next_count;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < REG_COUNT; i++) begin
            if (reset) begin
                r_regs[i] <= '0;
            end else if (w_wr_a[i]) begin
                r_regs[i] <= write_value_a;
            end else if (w_wr_b[i]) begin
                r_regs[i] <= write_value_b;
            end
        end
    end

    assign busy_count = r_busy_count;

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        read_value_1 = r_regs[read_selector_1];
        if (w_wr_a[read_selector_1]) begin
            read_value_1 = write_value_a;
        end else if (w_wr_b[read_selector_1]) begin
            read_value_1 = write_value_b;
        end
        read_value_2 = r_regs[read_selector_2];
        if (w_wr_a[read_selector_2]) begin
            read_value_2 = write_value_a;
        end else if (w_wr_b[read_selector_2]) begin
            read_value_2 = write_value_b;
        end
    end

    assign pending_1 = r_pending[read_selector_1] &
                       ~(w_clr[read_selector_1] & ~w_rsv[read_selector_1]);
    assign pending_2 = r_pending[read_selector_2] &
                       ~(w_clr[read_selector_2] & ~w_rsv[read_selector_2]);
`else
    // Register 0 is never written when hardwired, so it holds its reset zero.
    assign read_value_1 = r_regs[read_selector_1];
    assign read_value_2 = r_regs[read_selector_2];
    assign pending_1    = r_pending[read_selector_1];
    assign pending_2    = r_pending[read_selector_2];
`endif

endmodule
`default_nettype wire
